// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared types and default sizes for the hazard/scoreboard unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam int c_NREG_DEFAULT    = 32;
   localparam int c_AW_DEFAULT      = 5;
   localparam int c_MAX_OUT_DEFAULT = 4;

   typedef logic [c_AW_DEFAULT-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_W    = 2'b01,
      FWD_M    = 2'b10,
      FWD_LONG = 2'b11
   } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Per-register pending bits, outstanding long-op count, sticky error.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG    = c_NREG_DEFAULT,
   parameter int AW      = c_AW_DEFAULT,
   parameter int MAX_OUT = c_MAX_OUT_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue,
   input  logic [AW-1:0]   issue_rd,
   input  logic            retire,
   input  logic [AW-1:0]   retire_rd,
   output logic [NREG-1:0] pending,
   output logic            full,
   output logic            sb_err
);

   localparam int             CW    = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0]  c_MAX = CW'(MAX_OUT);

   logic [NREG-1:0] r_pend;
   logic [CW-1:0]   r_cnt;
   logic            r_err;

   logic [NREG-1:0] w_pend_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_ret_hit;
   logic            w_iss_hit;
   logic            w_retire_ok;
   logic            w_issue_ok;

   // x0 and out-of-range indices never hit, so they never touch state
   always_comb begin
      w_ret_hit = 1'b0;
      w_iss_hit = 1'b0;
      for (int i = 1; i < NREG; i++) begin
         if (retire_rd == AW'(i) && r_pend[i]) w_ret_hit = 1'b1;
         if (issue_rd == AW'(i))               w_iss_hit = 1'b1;
      end
      w_retire_ok = retire & w_ret_hit;
      w_issue_ok  = issue & w_iss_hit & ((r_cnt != c_MAX) | w_retire_ok);

      w_pend_nxt = r_pend;
      for (int i = 1; i < NREG; i++) begin
         if (w_retire_ok && retire_rd == AW'(i)) w_pend_nxt[i] = 1'b0;
         if (w_issue_ok && issue_rd == AW'(i))   w_pend_nxt[i] = 1'b1;
      end
      w_pend_nxt[0] = 1'b0;

      case ({w_issue_ok, w_retire_ok})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
         r_err  <= r_err | (retire & ~w_ret_hit);
      end
   end

   assign pending = r_pend;
   assign full    = (r_cnt == c_MAX);
   assign sb_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module  : hazard_scoreboard_unit
// Purpose : Stall/flush/forward control with long-op scoreboard.
//           Optional D/E bypass from the long writeback bus: LONG_WB_FWD_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int NREG    = c_NREG_DEFAULT,
   parameter int AW      = c_AW_DEFAULT,
   parameter int MAX_OUT = c_MAX_OUT_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RegWriteM,
   input  logic          RegWriteW,
   input  logic [AW-1:0] rdm,
   input  logic [AW-1:0] rdw,
   input  logic [AW-1:0] rde,
   input  logic [AW-1:0] rs1e,
   input  logic [AW-1:0] rs2e,
   input  logic [AW-1:0] rs1d,
   input  logic [AW-1:0] rs2d,
   input  logic [AW-1:0] rdd,
   input  logic          RegWriteD,
   input  logic          ResultSrcE0,
   input  logic          LongOpD,
   input  logic          LongOpE,
   input  logic          PCsrc,
   input  logic          long_wb_valid,
   input  logic [AW-1:0] long_wb_rd,
   output logic          long_wb_ready,
   output logic [1:0]    forwardae,
   output logic [1:0]    forwardbe,
   output logic          forwardad,
   output logic          forwardbd,
   output logic          stallf,
   output logic          stalld,
   output logic          flushd,
   output logic          flushe,
   output logic          sb_err
);

   logic [NREG-1:0] w_pend;
   logic            w_full;
   logic            w_retire;
   logic            w_byp1d, w_byp2d, w_long1e, w_long2e;
   logic            w_lw, w_raw, w_waw, w_fullstall, w_stall;

   function automatic logic pend_at(input logic [NREG-1:0] v, input logic [AW-1:0] idx);
      pend_at = 1'b0;
      for (int i = 0; i < NREG; i++)
         if (idx == AW'(i)) pend_at = v[i];
   endfunction

   // M has priority over W; the long bus only wins when neither pipeline stage matches
   function automatic fwd_sel_e fwd_e(input logic [AW-1:0] src, input logic long_hit);
      if (src != '0 && src == rdm && RegWriteM)      fwd_e = FWD_M;
      else if (src != '0 && src == rdw && RegWriteW) fwd_e = FWD_W;
      else if (long_hit)                             fwd_e = FWD_LONG;
      else                                           fwd_e = FWD_RF;
   endfunction

   assign long_wb_ready = ~RegWriteW;
   assign w_retire      = long_wb_valid & long_wb_ready;

   hazard_scoreboard #(
      .NREG    (NREG),
      .AW      (AW),
      .MAX_OUT (MAX_OUT)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .issue     (LongOpE & (rde != '0)),
      .issue_rd  (rde),
      .retire    (w_retire),
      .retire_rd (long_wb_rd),
      .pending   (w_pend),
      .full      (w_full),
      .sb_err    (sb_err)
   );

`ifdef LONG_WB_FWD_EN
   assign w_byp1d  = w_retire & (rs1d != '0) & (rs1d == long_wb_rd);
   assign w_byp2d  = w_retire & (rs2d != '0) & (rs2d == long_wb_rd);
   assign w_long1e = w_retire & (rs1e != '0) & (rs1e == long_wb_rd);
   assign w_long2e = w_retire & (rs2e != '0) & (rs2e == long_wb_rd);
`else
   assign w_byp1d  = 1'b0;
   assign w_byp2d  = 1'b0;
   assign w_long1e = 1'b0;
   assign w_long2e = 1'b0;
`endif

   assign forwardae = fwd_e(rs1e, w_long1e);
   assign forwardbe = fwd_e(rs2e, w_long2e);
   assign forwardad = w_byp1d;
   assign forwardbd = w_byp2d;

   assign w_lw        = ResultSrcE0 & (rde != '0) & ((rs1d == rde) | (rs2d == rde));
   assign w_raw       = ((rs1d != '0) & pend_at(w_pend, rs1d) & ~w_byp1d)
                      | ((rs2d != '0) & pend_at(w_pend, rs2d) & ~w_byp2d);
   assign w_waw       = RegWriteD & (rdd != '0) & pend_at(w_pend, rdd);
   assign w_fullstall = LongOpD & w_full;
   assign w_stall     = w_lw | w_raw | w_waw | w_fullstall;

   assign stallf = w_stall;
   assign stalld = w_stall;
   assign flushd = PCsrc;
   assign flushe = w_stall | PCsrc;

endmodule

`default_nettype wire
